// File: rtl/text_pkg.sv
// Shared definitions for the text normalizer: ASCII constants, the FSM state
// encoding and the byte classifier.
package text_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_Z_UP  = 8'h5A;
    localparam logic [7:0] CH_A_LO  = 8'h61;
    localparam logic [7:0] CH_Z_LO  = 8'h7A;

    typedef enum logic [1:0] {
        START = 2'd0,
        WORD  = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LETTER = 2'd0,
        SPACE  = 2'd1,
        END    = 2'd2,
        OTHER  = 2'd3
    } class_t;

    function automatic class_t classify(input logic [7:0] b);
        if ((b >= CH_A_UP && b <= CH_Z_UP) || (b >= CH_A_LO && b <= CH_Z_LO))
            return LETTER;
        else if (b == CH_SPACE || b == CH_TAB || b == CH_LF || b == CH_CR)
            return SPACE;
        else if (b == CH_NUL)
            return END;
        else
            return OTHER;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read from registered storage.
// Ports: clk, reset (async, active-high), wr_en/wr_data push, rd_en pops,
// rd_data is the head entry, full/empty flags, count = occupancy.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/text_normalizer.sv
// Normalizes a raw ASCII byte stream: folds letters to lower case, collapses
// whitespace runs to one 0x20, drops leading whitespace and illegal bytes,
// and buffers the result in a FIFO.
// Ports: clk, reset (async, active-high); in_valid/in_data/in_ready input
// handshake; out_valid/out_data/out_ready output handshake; count = FIFO
// occupancy; drop_count = saturating count of illegal bytes.
//
// state | meaning
// START | no pending word; whitespace and NUL are swallowed
// WORD  | inside a word; next separator emits one space
// GAP   | space already emitted; further whitespace is swallowed
module text_normalizer
    import text_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_count
);
    state_t     state;
    state_t     state_nxt;
    class_t     cls;
    logic       accept;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       drop_inc;
    logic       full;
    logic       empty;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign cls       = classify(in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= START;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_data   = CH_SPACE;
        drop_inc  = 1'b0;
        if (accept) begin
            case (cls)
                LETTER: begin
                    // Bit 5 set maps upper to lower and leaves lower unchanged.
                    wr_en     = 1'b1;
                    wr_data   = in_data | 8'h20;
                    state_nxt = WORD;
                end
                SPACE: begin
                    if (state == WORD) begin
                        wr_en     = 1'b1;
                        state_nxt = GAP;
                    end
                end
                END: begin
                    if (state == WORD)
                        wr_en = 1'b1;
                    state_nxt = START;
                end
                default: drop_inc = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (drop_inc && drop_count != '1)
            drop_count <= drop_count + 1'b1;
    end

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_text_normalizer.sv
module tb_text_normalizer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [3:0] count;
    logic [15:0] drop_count;

    logic       s_in_valid = 1'b0;
    logic [7:0] s_in_data = 8'h00;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic [3:0] s_count;
    logic [3:0] s_drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    text_normalizer #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .drop_count(drop_count)
    );

    text_normalizer #(.DEPTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b1),
        .count(s_count), .drop_count(s_drop_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output scoreboard: a pop is committed at the next posedge when
    // out_valid && out_ready hold at the negedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check_val("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check_val("out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cyc;
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (cyc = 0; cyc < 100 && !ok; cyc++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        if (!ok) check_val("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic push_list(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back(s[i]);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_val({tag, "_drain"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        check_val({tag, "_count0"}, count, 0);
    endtask

    initial begin
        // Reset values
        #2;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_count", count, 0);
        check_val("rst_drop", drop_count, 0);
        do_reset();

        // 1: case fold, whitespace collapse, NUL terminates word
        out_ready = 1'b1;
        push_list("begin end ");
        send_str("  Begin\tEND");
        send_byte(8'h00);
        wait_drain("t1");
        check_val("t1_drop", drop_count, 0);

        // 2: illegal bytes dropped without state change
        do_reset();
        out_ready = 1'b1;
        push_list("ab c");
        send_str("a,,b  c");
        wait_drain("t2");
        check_val("t2_drop", drop_count, 2);

        // 3: fill to full, backpressure, single pop frees one slot
        do_reset();
        out_ready = 1'b0;
        push_list("abcdefghi");
        send_str("abcdefgh");
        in_valid = 1'b1;
        in_data  = "i";
        @(negedge clk);
        check_val("t3_full_count", count, 8);
        check_val("t3_full_ready", in_ready, 0);
        check_val("t3_full_valid", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t3_held_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("t3_after_pop_ready", in_ready, 1);
        check_val("t3_after_pop_count", count, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("t3_refill_count", count, 8);
        out_ready = 1'b1;
        wait_drain("t3");

        // 4: steady push+pop with pointer wrap
        do_reset();
        out_ready = 1'b1;
        push_list("qrstuv");
        send_str("qrstuv");
        wait_drain("t4pre");
        out_ready = 1'b0;
        push_list("abc");
        send_str("abc");
        @(negedge clk);
        check_val("t4_count3", count, 3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_list("wxyz");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h77 + 8'(i);
            @(negedge clk);
            check_val("t4_steady_count", count, 3);
            check_val("t4_steady_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("t4");

        // 5: asynchronous reset mid-word
        do_reset();
        out_ready = 1'b0;
        send_str("hello");
        @(negedge clk);
        check_val("t5_count5", count, 5);
        #2 reset = 1'b1;
        #1;
        check_val("t5_rst_valid", out_valid, 0);
        check_val("t5_rst_count", count, 0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        push_list("x");
        send_str(" x");
        wait_drain("t5");

        // 6: saturating drop counter on the narrow instance
        for (int i = 0; i < 17; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'h21;
            @(posedge clk); #1;
            if (i == 14) check_val("t6_drop15", s_drop_count, 15);
            check_val("t6_no_valid", s_out_valid, 0);
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        check_val("t6_drop_sat", s_drop_count, 15);
        check_val("t6_count", s_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
